// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared state encodings and status-word bit positions for uart_rx.
// Revision : 1.0
// ============================================================================
package uart_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int RX_BYTE_W  = 8;
  localparam int RX_ENTRY_W = RX_BYTE_W + 1;  // {ferr, byte}

  localparam int RX_VALID = 8;
  localparam int RX_FERR  = 9;
  localparam int RX_OVR   = 10;

endpackage
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo
// Brief    : Synchronous FIFO with wrap-bit pointers; push accepted on full
//            only when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_do_pop;
  logic              w_do_push;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 serial receiver, 16x oversampling, FIFO-buffered status word.
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int TICK_DIV   = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int                DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  C_DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic                   r_rx_meta;
  logic                   r_rxs;
  logic [DIV_W-1:0]       r_div;
  logic                   w_tick;

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [3:0]             r_tcnt;
  logic [3:0]             w_tcnt_nxt;
  logic [2:0]             r_bcnt;
  logic [2:0]             w_bcnt_nxt;
  logic [RX_BYTE_W-1:0]   r_shift;
  logic [RX_BYTE_W-1:0]   w_shift_nxt;
  logic                   w_push;

  logic [RX_ENTRY_W-1:0]  w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   r_ovr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  assign w_tick = (r_div == C_DIV_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // tcnt is 4 bits, so a 16-tick interval is simply "tcnt == 15".
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    if (w_tick) begin
      case (r_state)
        RX_IDLE: begin
          if (!r_rxs) begin
            w_state_nxt = RX_START;
            w_tcnt_nxt  = '0;
          end
        end
        RX_START: begin
          w_tcnt_nxt = r_tcnt + 4'd1;
          if (r_tcnt == 4'd7) begin
            if (r_rxs) begin
              w_state_nxt = RX_IDLE;
            end else begin
              w_state_nxt = RX_DATA;
              w_tcnt_nxt  = '0;
              w_bcnt_nxt  = '0;
            end
          end
        end
        RX_DATA: begin
          w_tcnt_nxt = r_tcnt + 4'd1;
          if (r_tcnt == 4'd15) begin
            w_shift_nxt[r_bcnt] = r_rxs;
            w_bcnt_nxt          = r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) begin
              w_state_nxt = RX_STOP;
              w_tcnt_nxt  = '0;
            end
          end
        end
        RX_STOP: begin
          w_tcnt_nxt = r_tcnt + 4'd1;
          if (r_tcnt == 4'd15) begin
            w_push      = 1'b1;
            w_state_nxt = RX_IDLE;
          end
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end
  end

  rx_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (re),
    .wdata ({~r_rxs, r_shift}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // A same-cycle read makes room, so only an unserviced push onto full overruns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_ovr <= 1'b0;
    else if (re)                 r_ovr <= 1'b0;
    else if (w_push && w_full)   r_ovr <= 1'b1;
  end

  always_comb begin
    rdata         = '0;
    rdata[RX_OVR] = r_ovr;
    if (!w_empty) begin
      rdata[RX_BYTE_W-1:0] = w_head[RX_BYTE_W-1:0];
      rdata[RX_VALID]      = 1'b1;
      rdata[RX_FERR]       = w_head[RX_BYTE_W];
    end
  end

  assign irq = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx at TICK_DIV=2.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int TD      = 2;
  localparam int BIT_CLK = 16 * TD;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        re    = 1'b0;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(
    .TICK_DIV   (TD),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .re    (re),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic read_word(output logic [31:0] v);
    @(negedge clk);
    v  = rdata;
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] v_pp;
  logic        hit;
  logic [31:0] exp_ovr [5];
  logic [31:0] exp_pp  [5];

  initial begin
    exp_ovr[0] = 32'h501; exp_ovr[1] = 32'h102; exp_ovr[2] = 32'h103;
    exp_ovr[3] = 32'h104; exp_ovr[4] = 32'h000;
    exp_pp[0]  = 32'h122; exp_pp[1]  = 32'h133; exp_pp[2]  = 32'h144;
    exp_pp[3]  = 32'h177; exp_pp[4]  = 32'h000;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("single_irq", {31'd0, irq}, 32'h1);
    check("single_rdata", rdata, 32'h1A5);
    read_word(v);
    check("single_read", v, 32'h1A5);
    check("single_after_rdata", rdata, 32'h0);
    check("single_after_irq", {31'd0, irq}, 32'h0);

    // False start
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    check("false_irq", {31'd0, irq}, 32'h0);
    check("false_state", {30'd0, dut.r_state}, {30'd0, RX_IDLE});
    send_byte(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    read_word(v);
    check("false_next_byte", v, 32'h13C);

    // Framing error
    send_byte(8'h5A, 1'b0);
    rx = 1'b1;
    check("ferr_rdata", rdata, 32'h35A);
    repeat (12 * BIT_CLK) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("ferr_cleared", rdata, 32'h0);

    // Overrun: five back-to-back frames into a 4-deep FIFO
    for (int d = 1; d <= 5; d++) send_byte(8'(d), 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      read_word(v);
      check($sformatf("ovr_read%0d", i), v, exp_ovr[i]);
    end
    check("ovr_irq_end", {31'd0, irq}, 32'h0);

    // Pop and push on full: read coincides with the stop-sample push of 0x77
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    hit  = 1'b0;
    v_pp = '0;
    fork
      send_byte(8'h77, 1'b1);
      begin
        for (int i = 0; i < 12 * BIT_CLK && !hit; i++) begin
          @(negedge clk);
          if (dut.w_push) begin
            v_pp = rdata;
            re   = 1'b1;
            @(negedge clk);
            re   = 1'b0;
            hit  = 1'b1;
          end
        end
      end
    join
    check("pp_push_seen", {31'd0, hit}, 32'h1);
    check("pp_head_read", v_pp, 32'h111);
    for (int i = 0; i < 5; i++) begin
      read_word(v);
      check($sformatf("pp_read%0d", i), v, exp_pp[i]);
    end

    // Reset mid-frame
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (100) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'h0);
    send_byte(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    check("midrst_next_byte", rdata, 32'h112);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
